serial_word_loader: RTL and testbench
=====================================

Name: serial_word_loader

Overview:
Upstream feeder for the 4-bit shift/rotate register. It accepts a parallel word over a valid/ready handshake and serializes it onto In with Sr_En high for WIDTH cycles, MSB first. It then holds Sr_En low for ROT_CYCLES cycles so the downstream register rotates, and pulses Done when the downstream contents are settled. It also keeps a running count of completed words.

Parameters:
WIDTH, 4, word width and number of shift cycles; must match the downstream register width; legal range 2..16.
ROT_CYCLES, 4, rotate cycles after the shift phase (Sr_En=0); 0 skips the rotate phase; legal range 0..255.

Ports:
CLK  input  1  system clock, rising-edge.
CLR  input  1  reset; synchronous, active-high; sampled on the CLK rising edge.
Data_In  input  WIDTH  parallel word to serialize.
Load  input  1  valid; word is accepted on an edge where Load=1 and Ready=1.
Ready  output  1  high only in IDLE.
In  output  1  serial bit to the downstream In.
Sr_En  output  1  shift enable to the downstream Sr_En.
Busy  output  1  high in SHIFT, ROTATE and DONE.
Done  output  1  one-cycle pulse at the end of each word.
Word_Cnt  output  8  count of completed words; wraps 255->0.

Behaviour:
- Reset (CLR=1 at an edge): state=IDLE, shift buffer=0, bit/rotate counters=0, Word_Cnt=0.
  - Outputs after reset: Ready=1, In=0, Sr_En=0, Busy=0, Done=0.
  - CLR takes priority over every other input, in any state.
  - CLR mid-word abandons the word; no Done pulse; Word_Cnt unchanged from 0.
- States: IDLE, SHIFT, ROTATE, DONE. All outputs are registered or decoded from state and registers only; no combinational path from Load or Data_In to any output.
- IDLE:
  - Ready=1, Sr_En=0, In=0.
  - On an edge with Load=1: capture Data_In into the buffer, clear the bit counter, go to SHIFT.
  - Load=0: stay in IDLE.
- SHIFT:
  - Sr_En=1; In = current buffer MSB.
  - Each edge: shift the buffer left by 1 and increment the bit counter.
  - After WIDTH cycles: go to ROTATE, or to DONE if ROT_CYCLES=0.
  - Result: the word's bits appear on In in cycles 1..WIDTH after the accept edge, MSB first.
- ROTATE:
  - Sr_En=0, In=0.
  - Lasts exactly ROT_CYCLES cycles (8-bit counter), then go to DONE.
- DONE:
  - Exactly 1 cycle: Done=1, Sr_En=0, Ready=0.
  - Word_Cnt increments on the edge leaving DONE.
  - Next state is IDLE.
- Latency, accept edge to Done high: WIDTH+ROT_CYCLES+1 cycles. Next word can be accepted no earlier than WIDTH+ROT_CYCLES+2 cycles after the previous accept.
- Load while not Ready: ignored, not queued. Data_In changes during a word have no effect.
- Back-to-back words: Load held high through DONE is accepted on the first IDLE edge; one IDLE cycle is always present between words.
- Downstream note: in IDLE Sr_En=0, so the downstream register keeps rotating. With ROT_CYCLES a multiple of WIDTH, the downstream q equals the loaded word in the Done cycle.
- Word_Cnt at 255: the next completion wraps it to 0 with no flag.

Optional Feature:
LSB_FIRST_EN
- Defined: SHIFT drives In = buffer LSB and shifts right; bits go out LSB first. All timing is identical.
- Undefined (default): MSB first, as described in Behaviour.

Test Plan:
- CLR=1 for 1 edge, then Load=0 for 5 cycles -> Ready=1, Sr_En=0, In=0, Busy=0, Done=0, Word_Cnt=0 throughout.
- Data_In=4'b1011 with Load pulsed 1 cycle in IDLE:
  - cycles 1-4: Sr_En=1, In=1,0,1,1;
  - cycles 5-8: Sr_En=0;
  - cycle 9: Done=1;
  - cycle 10: Ready=1, Word_Cnt=1.
  - The downstream q in cycle 9 matches its value after the 4 shifts.
- Load=1 with Data_In=4'b0110 during cycle 3 of an active word -> ignored; the active word's serial stream is unchanged; Ready stays 0 until cycle 10.
- CLR=1 in cycle 2 of SHIFT -> next cycle: IDLE, Ready=1, Sr_En=0, no Done pulse, Word_Cnt=0.
- ROT_CYCLES=0, Data_In=4'b1000 -> In=1,0,0,0 in cycles 1-4; Done in cycle 5; Ready in cycle 6.
- 256 back-to-back words with Load held high -> Word_Cnt wraps to 0 after the 256th Done; accept edges are spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/serial_word_loader_if.sv
// Handshake and serial-output bundle between a word producer and serial_word_loader.
// WIDTH must match the loader's WIDTH parameter.
interface serial_word_loader_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] Data_In;
   logic             Load;
   logic             Ready;
   logic             In;
   logic             Sr_En;
   logic             Busy;
   logic             Done;
   logic [7:0]       Word_Cnt;

   modport master (
      output Data_In, Load,
      input  Ready, In, Sr_En, Busy, Done, Word_Cnt
   );

   modport slave (
      input  Data_In, Load,
      output Ready, In, Sr_En, Busy, Done, Word_Cnt
   );
endinterface

// File: rtl/serial_word_loader.sv
// Serializes a parallel word into a downstream shift/rotate register, then lets it rotate.
// Optional macro LSB_FIRST_EN: shift the word out LSB first instead of MSB first.
module serial_word_loader #(
   parameter int WIDTH      = 4,
   parameter int ROT_CYCLES = 4
) (
   input  logic                 CLK,
   input  logic                 CLR,
   serial_word_loader_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      ROTATE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [4:0] BIT_LAST = 5'(WIDTH - 1);
   localparam logic [7:0] ROT_LAST = 8'((ROT_CYCLES == 0) ? 0 : ROT_CYCLES - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shift_buf, shift_buf_nxt;
   logic [4:0]       bit_cnt, bit_cnt_nxt;
   logic [7:0]       rot_cnt, rot_cnt_nxt;
   logic [7:0]       word_cnt, word_cnt_nxt;
   logic             serial_bit;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state     <= IDLE;
         shift_buf <= '0;
         bit_cnt   <= '0;
         rot_cnt   <= '0;
         word_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         shift_buf <= shift_buf_nxt;
         bit_cnt   <= bit_cnt_nxt;
         rot_cnt   <= rot_cnt_nxt;
         word_cnt  <= word_cnt_nxt;
      end
   end

   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      state_nxt     = state;
      shift_buf_nxt = shift_buf;
      bit_cnt_nxt   = bit_cnt;
      rot_cnt_nxt   = rot_cnt;
      word_cnt_nxt  = word_cnt;

      unique case (state)
         IDLE: begin
            if (bus.Load) begin
               shift_buf_nxt = bus.Data_In;
               bit_cnt_nxt   = '0;
               state_nxt     = SHIFT;
            end
         end

         SHIFT: begin
`ifdef LSB_FIRST_EN
            shift_buf_nxt = {1'b0, shift_buf[WIDTH-1:1]};
`else
            shift_buf_nxt = {shift_buf[WIDTH-2:0], 1'b0};
`endif
            bit_cnt_nxt = bit_cnt + 5'd1;
            if (bit_cnt == BIT_LAST) begin
               rot_cnt_nxt = '0;
               state_nxt   = (ROT_CYCLES == 0) ? DONE : ROTATE;
            end
         end

         ROTATE: begin
            rot_cnt_nxt = rot_cnt + 8'd1;
            if (rot_cnt == ROT_LAST) begin
               state_nxt = DONE;
            end
         end

         DONE: begin
            // 8-bit counter wraps 255 -> 0 silently
            word_cnt_nxt = word_cnt + 8'd1;
            state_nxt    = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

`ifdef LSB_FIRST_EN
   assign serial_bit = shift_buf[0];
`else
   assign serial_bit = shift_buf[WIDTH-1];
`endif

   // Outputs decode from state and registers only; Load/Data_In never reach them combinationally.
   assign bus.Ready    = (state == IDLE);
   assign bus.Sr_En    = (state == SHIFT);
   assign bus.In       = (state == SHIFT) && serial_bit;
   assign bus.Busy     = (state != IDLE);
   assign bus.Done     = (state == DONE);
   assign bus.Word_Cnt = word_cnt;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader: table-driven word timing plus hand-written
// sequences for abort, zero-rotate and 256-word wrap.
module tb_serial_word_loader;

   logic clk;
   logic clr;

   int n_checks = 0;
   int n_fail   = 0;

   serial_word_loader_if #(.WIDTH(4)) bus  ();
   serial_word_loader_if #(.WIDTH(4)) bus0 ();

   serial_word_loader #(.WIDTH(4), .ROT_CYCLES(4)) dut (
      .CLK (clk),
      .CLR (clr),
      .bus (bus.slave)
   );

   serial_word_loader #(.WIDTH(4), .ROT_CYCLES(0)) dut0 (
      .CLK (clk),
      .CLR (clr),
      .bus (bus0.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the downstream 4-bit register: shifts In when Sr_En, otherwise rotates.
   logic [3:0] q;
   always @(posedge clk) begin
      if (clr)            q <= 4'd0;
      else if (bus.Sr_En) q <= {q[2:0], bus.In};
      else                q <= {q[2:0], q[3]};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       clr;
      logic       load;
      logic [3:0] data;
      logic       rdy;
      logic       ser;
      logic       sr_en;
      logic       busy;
      logic       done;
      logic [7:0] cnt;
      logic       chk_q;
   } vec_t;

   vec_t vecs [16];

   initial begin
      //           clr   load  data     rdy   ser   sr    busy  done  cnt   chk_q
      vecs[0]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 4'b0110, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 4'b0110, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};

      clr          = 1'b1;
      bus.Load     = 1'b0;
      bus.Data_In  = 4'd0;
      bus0.Load    = 1'b0;
      bus0.Data_In = 4'd0;
      #1;

      // Reset, idle, one word with a rejected Load mid-word.
      for (int i = 0; i < 16; i++) begin
         clr         = vecs[i].clr;
         bus.Load    = vecs[i].load;
         bus.Data_In = vecs[i].data;
         tick();
         check($sformatf("v%0d_ready", i), 32'(bus.Ready),    32'(vecs[i].rdy));
         check($sformatf("v%0d_in", i),    32'(bus.In),       32'(vecs[i].ser));
         check($sformatf("v%0d_sr_en", i), 32'(bus.Sr_En),    32'(vecs[i].sr_en));
         check($sformatf("v%0d_busy", i),  32'(bus.Busy),     32'(vecs[i].busy));
         check($sformatf("v%0d_done", i),  32'(bus.Done),     32'(vecs[i].done));
         check($sformatf("v%0d_cnt", i),   32'(bus.Word_Cnt), 32'(vecs[i].cnt));
         if (vecs[i].chk_q) check($sformatf("v%0d_q", i), 32'(q), 32'h0000_000b);
      end
      bus.Load = 1'b0;

      // CLR in cycle 2 of SHIFT abandons the word.
      begin
         int dones;
         bus.Load    = 1'b1;
         bus.Data_In = 4'b1111;
         tick();
         bus.Load = 1'b0;
         tick();
         check("abort_in_shift", 32'(bus.Sr_En), 32'd1);
         clr = 1'b1;
         tick();
         clr = 1'b0;
         check("abort_ready", 32'(bus.Ready),    32'd1);
         check("abort_sr_en", 32'(bus.Sr_En),    32'd0);
         check("abort_busy",  32'(bus.Busy),     32'd0);
         check("abort_cnt",   32'(bus.Word_Cnt), 32'd0);
         dones = 0;
         for (int c = 0; c < 12; c++) begin
            if (bus.Done) dones++;
            tick();
         end
         check("abort_no_done", 32'(dones), 32'd0);
         check("abort_cnt_after", 32'(bus.Word_Cnt), 32'd0);
      end

      // ROT_CYCLES=0 instance, word 1000.
      begin
         logic [3:0] exp_bits;
         exp_bits      = 4'b1000;
         bus0.Load     = 1'b1;
         bus0.Data_In  = exp_bits;
         tick();
         bus0.Load    = 1'b0;
         bus0.Data_In = 4'b0111;
         for (int c = 1; c <= 4; c++) begin
            check($sformatf("rot0_c%0d_sr_en", c), 32'(bus0.Sr_En), 32'd1);
            check($sformatf("rot0_c%0d_in", c),    32'(bus0.In),    32'(exp_bits[4-c]));
            tick();
         end
         check("rot0_c5_done",  32'(bus0.Done),  32'd1);
         check("rot0_c5_ready", 32'(bus0.Ready), 32'd0);
         tick();
         check("rot0_c6_ready", 32'(bus0.Ready),    32'd1);
         check("rot0_c6_done",  32'(bus0.Done),     32'd0);
         check("rot0_c6_cnt",   32'(bus0.Word_Cnt), 32'd1);
      end

      // 256 back-to-back words with Load held high; expect wrap and 10-cycle spacing.
      begin
         int  cyc, last_acc, n_acc, n_done;
         bit  finished;
         clr = 1'b1;
         tick();
         clr = 1'b0;
         check("b2b_start_cnt", 32'(bus.Word_Cnt), 32'd0);
         bus.Load = 1'b1;
         cyc      = 0;
         last_acc = -1;
         n_acc    = 0;
         n_done   = 0;
         finished = 1'b0;
         while (!finished && cyc < 256 * 10 + 50) begin
            if (bus.Done) begin
               n_done++;
               if (n_done == 256) begin
                  check("b2b_cnt_at_last_done", 32'(bus.Word_Cnt), 32'd255);
                  bus.Load = 1'b0;
                  tick();
                  check("b2b_cnt_wrapped", 32'(bus.Word_Cnt), 32'd0);
                  check("b2b_ready_after", 32'(bus.Ready),    32'd1);
                  finished = 1'b1;
               end
            end
            if (!finished) begin
               if (bus.Ready && bus.Load) begin
                  if (last_acc >= 0) check($sformatf("b2b_spacing%0d", n_acc), 32'(cyc - last_acc), 32'd10);
                  last_acc = cyc;
                  n_acc++;
                  bus.Data_In = 4'(n_acc);
               end
               tick();
               cyc++;
            end
         end
         check("b2b_completed", 32'(finished), 32'd1);
         check("b2b_accepts",   32'(n_acc),    32'd256);
         bus.Load = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
